// File: rtl/dmem_scan_pkg.sv
// Shared constants for the data-memory scan sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_scan_pkg;

  // Default geometry of the data memory
  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 16;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Operation select sampled with start
  localparam logic MODE_SUM  = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/dmem_scan.sv
// Walks a contiguous address range of the data memory: FILL writes a constant, SUM checksums it.
// Latency: SUM len=N done N+3 edges after start; FILL N+1; len=0 done after 1 edge.
// Backpressure: none; start is only sampled in IDLE and is dropped (not queued) otherwise.
module dmem_scan
  import dmem_scan_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] mem_rd_adr,
  output logic [ADDR_W-1:0] mem_wr_adr,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_dat_in,
  input  logic [DATA_W-1:0] mem_dat_out
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              r_state;
  logic                r_mode;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W:0]     r_len;
  logic [DATA_W-1:0]   r_fill;
  logic [ADDR_W:0]     r_cnt;
  logic                r_drain;
  logic                r_busy;
  logic                r_done;
  logic [DATA_W-1:0]   r_result;
  logic [ADDR_W-1:0]   r_rd_adr;
  logic [ADDR_W-1:0]   r_wr_adr;
  logic                r_wr_en;
  logic [DATA_W-1:0]   r_dat_in;
  logic [DATA_W-1:0]   r_acc;
  logic                r_rd_vld1;
  logic                r_rd_vld2;

  logic [ADDR_W-1:0]   w_adr;
  logic                w_last;
  logic                w_accept;

  // Address wraps naturally through the truncating add
  assign w_adr    = r_base + r_cnt[ADDR_W-1:0];
  assign w_last   = (r_cnt == (r_len - CNT_ONE));
  assign w_accept = (r_state == IDLE) && start;

  assign busy       = r_busy;
  assign done       = r_done;
  assign result     = r_result;
  assign mem_rd_adr = r_rd_adr;
  assign mem_wr_adr = r_wr_adr;
  assign mem_wr_en  = r_wr_en;
  assign mem_dat_in = r_dat_in;

  // Control FSM with registered memory-port and status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_mode   <= MODE_SUM;
      r_base   <= '0;
      r_len    <= '0;
      r_fill   <= '0;
      r_cnt    <= '0;
      r_drain  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_rd_adr <= '0;
      r_wr_adr <= '0;
      r_wr_en  <= 1'b0;
      r_dat_in <= '0;
    end else begin
      // Single-cycle strobes fall back unless a state re-asserts them
      r_done  <= 1'b0;
      r_wr_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mode  <= mode;
            r_base  <= base;
            r_len   <= len;
            r_fill  <= fill_val;
            r_cnt   <= '0;
            r_drain <= 1'b0;
            if (len == '0) begin
              // Empty range: report immediately with a zero checksum
              r_result <= '0;
              r_state  <= DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (r_mode == MODE_FILL) begin
            r_wr_adr <= w_adr;
            r_dat_in <= r_fill;
            r_wr_en  <= 1'b1;
          end else begin
            r_rd_adr <= w_adr;
          end
          r_cnt <= r_cnt + CNT_ONE;
          if (w_last) begin
            r_state <= (r_mode == MODE_FILL) ? DONE : DRAIN;
          end
        end
        DRAIN: begin
          // Two cycles: memory read register plus accumulator sample
          r_drain <= 1'b1;
          if (r_drain) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
          if (r_mode == MODE_SUM) begin
            r_result <= r_acc;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Checksum: track each read two edges forward to line up with registered read data
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc     <= '0;
      r_rd_vld1 <= 1'b0;
      r_rd_vld2 <= 1'b0;
    end else begin
      r_rd_vld1 <= (r_state == ISSUE) && (r_mode == MODE_SUM);
      r_rd_vld2 <= r_rd_vld1;
      if (w_accept) begin
        r_acc <= '0;
      end else if (r_rd_vld2) begin
        r_acc <= r_acc + mem_dat_out;
      end
    end
  end

endmodule

// File: doc/dmem_scan.md
# dmem_scan

Sequencer that sits directly upstream of the data-memory read block and drives its address, write-enable and write-data ports. On a start request it walks a contiguous address range, either filling it with a constant (FILL) or reading every word back through the memory's registered read port and returning a 16-bit wrapping checksum (SUM). It is used to initialise the data memory and to self-check its contents. The memory's read data is fed back in as an input.

## Interface
Parameters:
- ADDR_W, 10, memory address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 16, memory word width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request, sampled only in IDLE.
- mode  in  1  0 = SUM, 1 = FILL; sampled with start.
- base  in  ADDR_W  first address; sampled with start.
- len  in  ADDR_W+1  word count, 0..1024; sampled with start.
- fill_val  in  DATA_W  FILL data; sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- result  out  DATA_W  SUM checksum; holds until the next done.
- mem_rd_adr  out  ADDR_W  to memory rd_adr.
- mem_wr_adr  out  ADDR_W  to memory wr_adr.
- mem_wr_en  out  1  to memory wr_en.
- mem_dat_in  out  DATA_W  to memory dat_in.
- mem_dat_out  in  DATA_W  memory read data, registered one edge after mem_rd_adr.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 with len≠0 → ISSUE. Latch mode, base, len and fill_val; clear the issue counter and the accumulator.
  - start=1 with len=0 → DONE; result cleared to 0.
- ISSUE:
  - Each cycle, issue address (base + k) mod 2^ADDR_W, k = 0..len-1.
  - SUM: drive mem_rd_adr; mem_wr_en = 0.
  - FILL: drive mem_wr_adr, mem_dat_in = fill_val, mem_wr_en = 1.
  - After the last issue: SUM → DRAIN; FILL → DONE.
- DRAIN (SUM only): two cycles while the last read data arrives and is accumulated, then → DONE.
- Accumulation: acc ← (acc + mem_dat_out) mod 2^DATA_W. The accumulator samples mem_dat_out two edges after the matching mem_rd_adr was registered. Exactly len samples are taken.
- DONE: done = 1 for one cycle. In SUM mode, result ← acc (FILL leaves result unchanged). Then → IDLE.
- start outside IDLE is ignored; it is not queued.
- mem_wr_en is never 1 outside ISSUE in FILL mode.
- Reset (any state, mid-operation included): state = IDLE. busy, done, mem_wr_en, mem_rd_adr, mem_wr_adr, mem_dat_in, result and acc are all 0 after the reset edge. The operation in progress is abandoned.

## Timing
- All outputs are registered. E0 is the edge that samples start; Ek is k edges later.
- SUM, len = N:
  - mem_rd_adr = base+k-1 after Ek, for k = 1..N.
  - busy = 1 from E1; busy = 0 and done = 1 at E(N+3); result is valid at E(N+3).
  - Total start-to-done latency: N+3 cycles.
- FILL, len = N:
  - mem_wr_en = 1 with mem_wr_adr = base+k-1 after Ek, for k = 1..N.
  - mem_wr_en = 0 at E(N+1); done = 1 and busy = 0 at E(N+1).
- len = 0: done = 1 at E1; busy stays 0; no memory access.
- Back-to-back: a start held high during the done cycle is accepted at the following edge, since the FSM is in IDLE there. Minimum gap between operations is one cycle.

## Structure
- Shared package holds:
  - state encoding localparams: IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  - mode constants MODE_SUM = 1'b0 and MODE_FILL = 1'b1;
  - the ADDR_W and DATA_W defaults.
- Single module: FSM, issue counter, address generator and accumulator. No sub-module; the address adder and accumulator are too small to split out.
- Bench instantiates dmem_scan with a 1024-entry behavioural model of the data-memory read block: write on wr_en at the clock edge, registered read.

## Test plan
- FILL base=0, len=7, fill_val=0x1234, then SUM base=0, len=7 → mem[0..6] = 0x1234; result = 0x7F6C; done at E10 of the SUM.
- Wrap-around: FILL base=1022, len=4, fill_val=0x0001 → addresses 1022, 1023, 0, 1 written and mem[2] untouched. SUM over the same range → result = 0x0004.
- Overflow: FILL 0xFFFF at base=100, len=2; SUM → result = 0xFFFE. Full range: len=1024 FILL 0x0001, then SUM → result = 0x0400.
- len=0 with either mode → done at E1; busy never asserted; mem_wr_en stays 0; result = 0 for SUM.
- start pulsed at E2 of a SUM with len=5 → ignored; exactly one done, at E8.
- reset driven low at E3 of a FILL with len=10 → after the reset edge all outputs are 0 and mem_wr_en = 0. Only addresses base..base+2 were written. A new start after reset behaves normally.
